// File: rtl/addr_scan_ctrl.sv
// Address sequencer that feeds the select input of a 4-to-16 decoder.
// Supports single, scan-up and scan-down sequences with per-address dwell, pause and abort.
module addr_scan_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       pause,
  input  logic [1:0] mode,
  input  logic [3:0] start_addr,
  input  logic [3:0] end_addr,
  input  logic [3:0] dwell,
  output logic [3:0] addr,
  output logic       addr_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b10;

  state_e     state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] dwell_cnt_q, dwell_cnt_d;
  logic [1:0] mode_q, mode_d;
  logic [3:0] end_q, end_d;
  logic [3:0] dwell_q, dwell_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [3:0] addr_step;

  // Any mode other than scan-down steps upward; single mode never steps
  // because its latched end equals its start.
  always_comb begin
    if (mode_q == MODE_DOWN) begin
      addr_step = addr_q - 4'd1;
    end else begin
      addr_step = addr_q + 4'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    dwell_cnt_d = dwell_cnt_q;
    mode_d      = mode_q;
    end_d       = end_q;
    dwell_d     = dwell_q;
    valid_d     = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d      = mode;
          end_d       = (mode == MODE_SINGLE) ? start_addr : end_addr;
          dwell_d     = dwell;
          addr_d      = start_addr;
          dwell_cnt_d = dwell;
          state_d     = RUN;
          valid_d     = 1'b1;
          busy_d      = 1'b1;
        end
      end

      RUN: begin
        // Abort outranks pause and stepping; addr keeps its last value.
        if (abort) begin
          state_d = IDLE;
        end else if (pause) begin
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else if (dwell_cnt_q != 4'd0) begin
          dwell_cnt_d = dwell_cnt_q - 4'd1;
          valid_d     = 1'b1;
          busy_d      = 1'b1;
        end else if (addr_q != end_q) begin
          addr_d      = addr_step;
          dwell_cnt_d = dwell_q;
          valid_d     = 1'b1;
          busy_d      = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= 4'd0;
      dwell_cnt_q <= 4'd0;
      mode_q      <= 2'd0;
      end_q       <= 4'd0;
      dwell_q     <= 4'd0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      dwell_cnt_q <= dwell_cnt_d;
      mode_q      <= mode_d;
      end_q       <= end_d;
      dwell_q     <= dwell_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_addr_scan_ctrl.sv
// Directed bench for addr_scan_ctrl: each check compares {addr, addr_valid, busy, done}
// against hand-computed values, sampled 1 time unit after the rising edge.
module tb_addr_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       pause;
  logic [1:0] mode;
  logic [3:0] start_addr;
  logic [3:0] end_addr;
  logic [3:0] dwell;
  logic [3:0] addr;
  logic       addr_valid;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  addr_scan_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .pause      (pause),
    .mode       (mode),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .dwell      (dwell),
    .addr       (addr),
    .addr_valid (addr_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got addr=%0d valid=%0b busy=%0b done=%0b, expected addr=%0d valid=%0b busy=%0b done=%0b",
               tag, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] a, input logic v,
                            input logic b, input logic d);
    check_val(tag, {addr, addr_valid, busy, done}, {a, v, b, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] m, input logic [3:0] sa, input logic [3:0] ea,
                        input logic [3:0] dw);
    mode       = m;
    start_addr = sa;
    end_addr   = ea;
    dwell      = dw;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 20000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq_down [8];
    seq_down = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd15, 4'd15, 4'd14, 4'd14};

    rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
    mode = 2'd0; start_addr = 4'd0; end_addr = 4'd0; dwell = 4'd0;
    #1;
    expect_out("reset_async", 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    expect_out("idle_after_reset", 4'd0, 1'b0, 1'b0, 1'b0);

    // Scan-up 2..5, dwell 0
    launch(2'b01, 4'd2, 4'd5, 4'd0);
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("up_addr%0d", 2 + i), 4'(2 + i), 1'b1, 1'b1, 1'b0);
      tick();
    end
    expect_out("up_done", 4'd5, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("up_idle", 4'd5, 1'b0, 1'b0, 1'b0);

    // Scan-down 1..14 with wrap, dwell 1; operands changed mid-run must be ignored
    launch(2'b10, 4'd1, 4'd14, 4'd1);
    mode = 2'b01; start_addr = 4'd9; end_addr = 4'd3; dwell = 4'd5;
    for (int i = 0; i < 8; i++) begin
      expect_out($sformatf("down_c%0d", i), seq_down[i], 1'b1, 1'b1, 1'b0);
      tick();
    end
    expect_out("down_done", 4'd14, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("down_idle", 4'd14, 1'b0, 1'b0, 1'b0);

    // Pause at addr 4 for 3 cycles, then abort (with pause) at addr 9
    launch(2'b01, 4'd0, 4'd15, 4'd0);
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("pa_addr%0d", i), 4'(i), 1'b1, 1'b1, 1'b0);
      tick();
    end
    expect_out("pa_addr4", 4'd4, 1'b1, 1'b1, 1'b0);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("pa_hold%0d", i), 4'd4, 1'b1, 1'b1, 1'b0);
    end
    pause = 1'b0;
    for (int i = 5; i < 10; i++) begin
      tick();
      expect_out($sformatf("pa_addr%0d", i), 4'(i), 1'b1, 1'b1, 1'b0);
    end
    abort = 1'b1; pause = 1'b1;
    tick();
    abort = 1'b0; pause = 1'b0;
    expect_out("abort_idle", 4'd9, 1'b0, 1'b0, 1'b0);
    abort = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      expect_out($sformatf("abort_nodone%0d", i), 4'd9, 1'b0, 1'b0, 1'b0);
    end
    abort = 1'b0;

    // Single mode: end_addr ignored, start held high through RUN and DONE is ignored
    launch(2'b00, 4'd7, 4'd3, 4'd2);
    expect_out("single_c0", 4'd7, 1'b1, 1'b1, 1'b0);
    start = 1'b1;
    tick();
    expect_out("single_c1", 4'd7, 1'b1, 1'b1, 1'b0);
    tick();
    expect_out("single_c2", 4'd7, 1'b1, 1'b1, 1'b0);
    tick();
    expect_out("single_done", 4'd7, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("single_done_ign_start", 4'd7, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    tick();
    expect_out("single_idle", 4'd7, 1'b0, 1'b0, 1'b0);

    // Reserved mode behaves as scan-up, wrapping 14 -> 1
    launch(2'b11, 4'd14, 4'd1, 4'd0);
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("rsv_c%0d", i), 4'(14 + i), 1'b1, 1'b1, 1'b0);
      tick();
    end
    expect_out("rsv_done", 4'd1, 1'b0, 1'b0, 1'b1);

    // start == end in scan-down: one address for dwell+1 = 1 cycle
    tick();
    launch(2'b10, 4'd5, 4'd5, 4'd0);
    expect_out("eq_c0", 4'd5, 1'b1, 1'b1, 1'b0);
    tick();
    expect_out("eq_done", 4'd5, 1'b0, 1'b0, 1'b1);
    tick();

    // Asynchronous reset mid-run at addr 6
    launch(2'b01, 4'd4, 4'd12, 4'd0);
    tick();
    tick();
    expect_out("rst_pre", 4'd6, 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    expect_out("rst_async_mid", 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    expect_out("rst_released", 4'd0, 1'b0, 1'b0, 1'b0);
    launch(2'b01, 4'd10, 4'd11, 4'd0);
    expect_out("rst_restart10", 4'd10, 1'b1, 1'b1, 1'b0);
    tick();
    expect_out("rst_restart11", 4'd11, 1'b1, 1'b1, 1'b0);
    tick();
    expect_out("rst_restart_done", 4'd11, 1'b0, 1'b0, 1'b1);
    tick();

    // Full 0..15 decoder feed
    launch(2'b01, 4'd0, 4'd15, 4'd0);
    for (int i = 0; i < 16; i++) begin
      expect_out($sformatf("full_addr%0d", i), 4'(i), 1'b1, 1'b1, 1'b0);
      tick();
    end
    expect_out("full_done", 4'd15, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("full_idle", 4'd15, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/addr_scan_ctrl.md
ADDR_SCAN_CTRL -- requirements
Module: addr_scan_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: begin a sequence; honoured only in IDLE.
REQ-004 SHALL have port abort, input, 1 bit: terminate a running sequence.
REQ-005 SHALL have port pause, input, 1 bit: freeze sequencing while high.
REQ-006 SHALL have port mode, input, 2 bits: 00 single, 01 scan-up, 10 scan-down, 11 reserved (behaves as scan-up).
REQ-007 SHALL have port start_addr, input, 4 bits: first address of the sequence.
REQ-008 SHALL have port end_addr, input, 4 bits: last address of the sequence; ignored in single mode.
REQ-009 SHALL have port dwell, input, 4 bits: extra cycles each address is held; hold time is dwell+1 cycles.
REQ-010 SHALL have port addr, output, 4 bits: registered select, feeding the A input of the 4-to-16 decoder.
REQ-011 SHALL have port addr_valid, output, 1 bit: addr is an active select this cycle.
REQ-012 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse at normal sequence completion.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 In IDLE with start=1, SHALL latch mode, start_addr, end_addr and dwell. In single mode the latched end equals start_addr.
REQ-016 After the start edge, SHALL enter RUN on the next cycle with addr=start_addr, dwell_cnt=dwell, addr_valid=1 and busy=1.
REQ-017 Changes to the input operands during RUN SHALL have no effect; only the latched copies are used.
REQ-018 In RUN with pause=1 and abort=0, SHALL hold addr, dwell_cnt and state unchanged, and addr_valid SHALL stay 1.
REQ-019 In RUN with pause=0 and dwell_cnt!=0, SHALL decrement dwell_cnt.
REQ-020 In RUN with pause=0, dwell_cnt=0 and addr!=latched end, SHALL step addr and reload dwell_cnt.
  - Scan-up: addr+1 modulo 16.
  - Scan-down: addr-1 modulo 16.
REQ-021 In RUN with pause=0, dwell_cnt=0 and addr==latched end, SHALL go to DONE.
REQ-022 Wrap-around SHALL be legal in both directions.
  - Scan-up from 14 to 1 visits 14, 15, 0, 1.
  - Scan-down from 1 to 14 visits 1, 0, 15, 14.
REQ-023 When start_addr==end_addr, SHALL present a single address for dwell+1 cycles in any mode.
REQ-024 In DONE, SHALL for exactly one cycle drive done=1, addr_valid=0 and busy=0, then return to IDLE.
REQ-025 abort=1 in RUN SHALL go to IDLE next cycle with addr_valid=0, busy=0 and no done pulse; abort has priority over pause and stepping.
REQ-026 SHALL ignore start in RUN and DONE, and ignore abort in IDLE and DONE.
REQ-027 Outside RUN, addr SHALL hold its last value while addr_valid=0.
REQ-028 Every output SHALL be a register output; no combinational path from any input to any output.

Reset
REQ-029 Asserting rst SHALL immediately force the following, regardless of clk:
  - state=IDLE.
  - addr=0, addr_valid=0, busy=0, done=0.
  - dwell_cnt=0 and all latched operands=0.
REQ-030 rst asserted mid-sequence SHALL abandon the sequence with no done pulse; after release, the first start behaves per REQ-015.

Verification
REQ-031 Scan-up: start at edge 0 with mode=01, start_addr=2, end_addr=5, dwell=0 -> addr 2,3,4,5 with addr_valid=1 at edges 1-4; done=1 at edge 5; busy=0 and addr_valid=0 from edge 5.
REQ-032 Scan-down with wrap and dwell: mode=10, start_addr=1, end_addr=14, dwell=1 -> addr 1,1,0,0,15,15,14,14 over 8 cycles, then a single done pulse.
REQ-033 Pause and abort: mode=01, start_addr=0, end_addr=15, dwell=0, pause high 3 cycles while addr=4 -> addr=4 held 4 cycles total; later abort while addr=9 -> next cycle IDLE, addr_valid=0, addr=9, done never asserted.
REQ-034 Single mode and ignored start: mode=00, start_addr=7, end_addr=3, dwell=2 -> addr=7 valid 3 cycles then done; start pulsed during RUN has no effect.
REQ-035 Reset mid-RUN: rst raised asynchronously between edges while addr=6 -> all outputs 0 before the next edge; after release, a new start with start_addr=10 yields addr=10 one cycle later.
REQ-036 Exhaustive decode feed: mode=01, start_addr=0, end_addr=15, dwell=0 -> 16 consecutive valid addresses 0-15 driving the downstream decoder; done on the 17th cycle.
